// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

    // Default operand width in bits
    localparam int DEF_WIDTH = 8;

    // FSM state encoding
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders and an OR of their carries.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .x (a),
        .y (b),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha1 (
        .x (s1),
        .y (cin),
        .s (s),
        .c (c2)
    );

    assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, result registered on completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] psum_next;

    // The single shared full adder sees the current LSBs and the running carry
    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (bit_s),
        .cout (bit_c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at position 0
    assign psum_next = {bit_s, psum[WIDTH-1:1]};

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // FSM, operand shifters, carry, bit counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        psum  <= '0;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    psum  <= psum_next;
                    carry <= bit_c;
                    if (cnt == LAST_BIT) begin
                        sum   <= psum_next;
                        cout  <= bit_c;
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for the bit-serial adder (WIDTH = 8).
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = DEF_WIDTH;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int tests;
    int fails;
    int cyc;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present operands with start for exactly one edge (edge 0), then scramble inputs
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        tick();
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (sum !== 8'h00) begin fails++; $display("FAIL reset_sum got %h want 00", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout got %b want 0", cout); end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_idle got busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_basic();
        start_op(8'h05, 8'h03, 1'b0);
        for (int i = 1; i <= W; i++) begin
            tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL basic_busy edge%0d got busy=%b done=%b want 1/0", i, busy, done); end
            tests++; if (sum !== 8'h00) begin fails++; $display("FAIL basic_sum_hold edge%0d got %h want 00", i, sum); end
            tick();
        end
        tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL basic_done got done=%b busy=%b want 1/0", done, busy); end
        tests++; if (sum !== 8'h08 || cout !== 1'b0) begin fails++; $display("FAIL basic_result got %b_%h want 0_08", cout, sum); end
        tick();
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL basic_pulse got done=%b busy=%b want 0/0", done, busy); end
        tests++; if (sum !== 8'h08) begin fails++; $display("FAIL basic_hold got %h want 08", sum); end
    endtask

    task automatic test_carry_ripple();
        int n;
        start_op(8'hFF, 8'h01, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        tests++; if (n != W) begin fails++; $display("FAIL ripple_latency got %0d want %0d", n, W); end
        tests++; if (sum !== 8'h00 || cout !== 1'b1) begin fails++; $display("FAIL ripple_result got %b_%h want 1_00", cout, sum); end
        tick();
    endtask

    task automatic test_full_carry_in();
        int n;
        start_op(8'hFF, 8'hFF, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        tests++; if (n != W) begin fails++; $display("FAIL cin_latency got %0d want %0d", n, W); end
        tests++; if (sum !== 8'hFF || cout !== 1'b1) begin fails++; $display("FAIL cin_result got %b_%h want 1_FF", cout, sum); end
        tick();
    endtask

    task automatic test_start_during_run();
        int pulses;
        int first_at;
        logic [W-1:0] got;
        start_op(8'h10, 8'h20, 1'b0);
        tick();
        tick();
        start = 1'b1;
        a     = 8'hAA;
        tick();
        start = 1'b0;
        pulses   = 0;
        first_at = -1;
        got      = '0;
        for (int e = 3; e <= 16; e++) begin
            if (done === 1'b1) begin
                pulses++;
                if (first_at < 0) begin first_at = e; got = sum; end
            end
            tick();
        end
        tests++; if (pulses != 1) begin fails++; $display("FAIL run_start_pulses got %0d want 1", pulses); end
        tests++; if (first_at != W) begin fails++; $display("FAIL run_start_latency got %0d want %0d", first_at, W); end
        tests++; if (got !== 8'h30) begin fails++; $display("FAIL run_start_sum got %h want 30", got); end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        int n;
        start_op(8'h0F, 8'h0F, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midrst_ctrl got busy=%b done=%b want 0/0", busy, done); end
        tests++; if (sum !== 8'h00 || cout !== 1'b0) begin fails++; $display("FAIL midrst_result got %b_%h want 0_00", cout, sum); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            tick();
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL midrst_no_done got %0d active cycles want 0", pulses); end
        start_op(8'h01, 8'h02, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        tests++; if (n != W) begin fails++; $display("FAIL midrst_latency got %0d want %0d", n, W); end
        tests++; if (sum !== 8'h03 || cout !== 1'b0) begin fails++; $display("FAIL midrst_after got %b_%h want 0_03", cout, sum); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        int t1;
        int t2;
        start_op(8'h01, 8'h01, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        t1 = cyc;
        tests++; if (n != W) begin fails++; $display("FAIL b2b_latency1 got %0d want %0d", n, W); end
        tests++; if (sum !== 8'h02 || cout !== 1'b0) begin fails++; $display("FAIL b2b_result1 got %b_%h want 0_02", cout, sum); end
        start_op(8'h80, 8'h80, 1'b0);
        tests++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_single_pulse got done=%b busy=%b want 0/1", done, busy); end
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        t2 = cyc;
        tests++; if (t2 - t1 != W + 1) begin fails++; $display("FAIL b2b_spacing got %0d want %0d", t2 - t1, W + 1); end
        tests++; if (sum !== 8'h00 || cout !== 1'b1) begin fails++; $display("FAIL b2b_result2 got %b_%h want 1_00", cout, sum); end
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_end_pulse got %b want 0", done); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        test_reset();
        test_basic();
        test_carry_ripple();
        test_full_carry_in();
        test_start_during_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (minimum 2).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new addition; sampled only when the block is ready.
REQ-006 a  input  WIDTH  augend, captured on an accepted start.
REQ-007 b  input  WIDTH  addend, captured on an accepted start.
REQ-008 cin  input  1  carry-in, captured on an accepted start.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  one-cycle pulse marking that sum/cout are updated.
REQ-011 sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH.
REQ-012 cout  output  1  registered carry out of the MSB.

Function
REQ-013 The block SHALL use a three-state FSM: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL do all of the following: capture a, b and cin into internal shift/carry registers; clear the bit counter; go to RUN.
REQ-015 In IDLE or DONE with start=0, the FSM SHALL go to (or stay in) IDLE.
REQ-016 In RUN, each rising edge SHALL process one bit, LSB first: s = a0^b0^c, c_next = a0&b0 | c&(a0^b0).
REQ-017 In RUN, the operand registers SHALL shift right by one bit and s SHALL shift into the MSB of the internal partial-sum register.
REQ-018 The edge that processes bit WIDTH-1 SHALL load sum from the completed partial sum, load cout from c_next, and move the FSM to DONE.
REQ-019 Latency: done SHALL be high in exactly the cycle following the WIDTH-th rising edge after the edge that accepted start.
REQ-020 done SHALL be high only in DONE.
REQ-021 busy SHALL equal (state==RUN).
REQ-022 start while in RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-023 sum and cout SHALL hold their values from the last completion until the next completion; they SHALL NOT change during RUN.
REQ-024 A start accepted in DONE (back-to-back) SHALL begin the new addition with no idle cycle, and done SHALL still pulse for one cycle only.
REQ-025 Changes on a, b or cin after the accepting edge SHALL NOT affect the result.
REQ-026 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL wrap only through the RUN->DONE transition.

Reset
REQ-027 When rst=1 at a rising edge, the FSM SHALL go to IDLE and busy, done, sum, cout, the counter and all internal registers SHALL be cleared to 0.
REQ-028 rst SHALL take priority over start.
REQ-029 rst asserted mid-RUN SHALL abort the addition with no done pulse.

Structure
REQ-030 The state encoding type and the default width constant SHALL live in a shared package used by the block and its bench.
REQ-031 The per-bit arithmetic SHALL be a sub-module, full_adder, instantiated once and built from two half_adder instances plus an OR of their carries.

Verification (WIDTH=8; edge 0 = the edge that accepts start)
REQ-032 Basic add: a=0x05, b=0x03, cin=0 -> done high after edge 8; sum=0x08, cout=0; busy high from edge 1 through edge 8 only.
REQ-033 Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
REQ-034 Full carry-in: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-035 Start during RUN: a=0x10, b=0x20; then at edge 3 drive start=1, a=0xAA -> the extra start is ignored; sum=0x30, exactly one done pulse.
REQ-036 Reset mid-RUN: a=0x0F, b=0x0F, then rst at edge 4 -> no done pulse; all outputs 0 after reset; a following start with a=0x01, b=0x02 -> sum=0x03.
REQ-037 Back-to-back: 0x01+0x01, then start in DONE with 0x80+0x80 -> two done pulses 9 cycles apart; sum=0x02/cout=0, then sum=0x00/cout=1.
